// File: rtl/sequence_checker_pkg.sv
// Shared definitions for both ends of the 4-bit sequence link: the width, the
// terminal value, the lock thresholds, the checker state encoding and succ().
package sequence_checker_pkg;

    localparam int WIDTH       = 4;
    localparam int MAX         = 15;
    localparam int LOCK_CNT    = 3;
    localparam int UNLOCK_ERRS = 2;
    localparam int CNT_W       = 8;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    function automatic logic [WIDTH-1:0] succ(input logic [WIDTH-1:0] x, input int max_v);
        return (int'(x) == max_v) ? '0 : x + WIDTH'(1);
    endfunction

    // Values above the terminal value can never appear on a healthy link.
    function automatic logic in_range(input logic [WIDTH-1:0] x, input int max_v);
        return int'(x) <= max_v;
    endfunction

endpackage

// File: rtl/sequence_checker_if.sv
// Signal bundle between the sequence counter's O bus and the checker.
// EN qualifies DIN as valid on a rising edge; there is no ready because the
// checker accepts every enabled sample on the edge it arrives.
interface sequence_checker_if
    import sequence_checker_pkg::*;
#(
    parameter int W = WIDTH
);
    logic             EN;
    logic [W-1:0]     DIN;
    logic             LOCK;
    logic             ERR;
    logic [CNT_W-1:0] ERR_CNT;
    logic [W-1:0]     EXP;
    state_t           state;

    modport master (output EN, DIN, input LOCK, ERR, ERR_CNT, EXP, state);
    modport slave  (input EN, DIN, output LOCK, ERR, ERR_CNT, EXP, state);
endinterface

// File: rtl/sequence_checker_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/sequence_checker.sv
// Receive-side checker for the sequence counter: locks after a run of correct
// successors and flags every break while locked, with a saturating error count.
module sequence_checker
    import sequence_checker_pkg::*;
(
    input logic               CLK,
    input logic               RST_N,
    sequence_checker_if.slave bus
);

    localparam logic [3:0] LOCK_CNT_V = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_V   = 4'(UNLOCK_ERRS);

    state_t           state_q, state_d;
    logic [3:0]       run_q, run_d;
    logic [3:0]       miss_q, miss_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             prev_valid_q, prev_valid_d;
    logic             err_q, err_d;
    logic             good;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= SEARCH;
            run_q        <= '0;
            miss_q       <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            miss_q       <= miss_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        run_d        = run_q;
        miss_d       = miss_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        err_d        = 1'b0;
        good         = (bus.DIN == succ(prev_q, MAX)) && in_range(bus.DIN, MAX);

        if (bus.EN) begin
            // Always resynchronise to whatever arrived, judged or not.
            prev_d       = bus.DIN;
            prev_valid_d = 1'b1;
            if (prev_valid_q) begin
                case (state_q)
                    SEARCH: begin
                        if (!good) begin
                            run_d = '0;
                        end else if (run_q + 4'd1 == LOCK_CNT_V) begin
                            state_d = LOCKED;
                            run_d   = '0;
                            miss_d  = '0;
                        end else begin
                            run_d = run_q + 4'd1;
                        end
                    end
                    LOCKED: begin
                        if (good) begin
                            miss_d = '0;
                        end else begin
                            err_d = 1'b1;
                            if (miss_q + 4'd1 == UNLOCK_V) begin
                                state_d = SEARCH;
                                run_d   = '0;
                                miss_d  = '0;
                            end else begin
                                miss_d = miss_q + 4'd1;
                            end
                        end
                    end
                    default: state_d = SEARCH;
                endcase
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (CLK),
        .rst_n (RST_N),
        .inc   (err_d),
        .count (bus.ERR_CNT)
    );

    assign bus.LOCK  = (state_q == LOCKED);
    assign bus.ERR   = err_q;
    assign bus.EXP   = prev_valid_q ? succ(prev_q, MAX) : '0;
    assign bus.state = state_q;

endmodule

// File: tb/tb_sequence_checker.sv
// Randomised and directed bench for sequence_checker against an integer-level
// model of the lock/unlock rules.
module tb_sequence_checker;
    import sequence_checker_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    sequence_checker_if #(.W(WIDTH)) bus ();

    sequence_checker dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: plain integers, history-based rules
    int m_prev;
    bit m_have_prev;
    int m_good_run;
    int m_bad_run;
    bit m_locked;
    bit m_err;
    int m_errs;

    // expected {LOCK, ERR, ERR_CNT[7:0], EXP[3:0]}
    logic [13:0] exp_q[$];

    function automatic int m_next(int x);
        return (x + 1) % (MAX + 1);
    endfunction

    task automatic model_reset();
        m_prev      = 0;
        m_have_prev = 0;
        m_good_run  = 0;
        m_bad_run   = 0;
        m_locked    = 0;
        m_err       = 0;
        m_errs      = 0;
    endtask

    task automatic model_step(input bit en, input int din);
        bit ok;
        int e;
        m_err = 0;
        if (en) begin
            if (m_have_prev) begin
                ok = (din <= MAX) && (din == m_next(m_prev));
                if (!m_locked) begin
                    m_good_run = ok ? m_good_run + 1 : 0;
                    if (m_good_run == LOCK_CNT) begin
                        m_locked   = 1;
                        m_good_run = 0;
                        m_bad_run  = 0;
                    end
                end else if (ok) begin
                    m_bad_run = 0;
                end else begin
                    m_err     = 1;
                    m_errs    = (m_errs < 255) ? m_errs + 1 : 255;
                    m_bad_run = m_bad_run + 1;
                    if (m_bad_run == UNLOCK_ERRS) begin
                        m_locked   = 0;
                        m_good_run = 0;
                        m_bad_run  = 0;
                    end
                end
            end
            m_prev      = din;
            m_have_prev = 1;
        end
        e = m_have_prev ? m_next(m_prev) : 0;
        exp_q.push_back({m_locked, m_err, 8'(m_errs), 4'(e)});
    endtask

    // scoreboard
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic score(input string tag);
        logic [13:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_queue got=empty want=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check_eq({tag, "_lock"},   32'(bus.LOCK),    32'(e[13]));
            check_eq({tag, "_err"},    32'(bus.ERR),     32'(e[12]));
            check_eq({tag, "_errcnt"}, 32'(bus.ERR_CNT), 32'(e[11:4]));
            check_eq({tag, "_exp"},    32'(bus.EXP),     32'(e[3:0]));
        end
    endtask

    // driver
    task automatic drive(input string tag, input bit en, input int din);
        @(negedge clk);
        bus.EN  = en;
        bus.DIN = 4'(din);
        @(posedge clk);
        model_step(en, din);
        #1;
        score(tag);
    endtask

    task automatic feed_seq(input string tag, input int first, input int count);
        int v;
        v = first;
        for (int i = 0; i < count; i++) begin
            drive(tag, 1'b1, v);
            v = m_next(v);
        end
    endtask

    initial begin
        int v;
        checks  = 0;
        errors  = 0;
        bus.EN  = 1'b0;
        bus.DIN = '0;
        rst_n   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_lock",   32'(bus.LOCK),    32'd0);
        check_eq("rst_err",    32'(bus.ERR),     32'd0);
        check_eq("rst_errcnt", 32'(bus.ERR_CNT), 32'd0);
        check_eq("rst_exp",    32'(bus.EXP),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // lock acquisition on 0,1,2,3
        feed_seq("acq", 0, 4);
        check_eq("acq_lock_on_3", 32'(bus.LOCK), 32'd1);
        check_eq("acq_exp_4",     32'(bus.EXP),  32'd4);

        // walk to 13 then cross the wrap
        feed_seq("walk", 4, 10);
        feed_seq("wrap", 14, 4);
        check_eq("wrap_lock",   32'(bus.LOCK),    32'd1);
        check_eq("wrap_errcnt", 32'(bus.ERR_CNT), 32'd0);
        check_eq("wrap_exp",    32'(bus.EXP),     32'd2);

        // single glitch: 5 -> 9 -> 10
        feed_seq("to5", 2, 4);
        drive("glitch9", 1'b1, 9);
        check_eq("glitch_err", 32'(bus.ERR), 32'd1);
        drive("glitch10", 1'b1, 10);
        check_eq("glitch_err_drop", 32'(bus.ERR),     32'd0);
        check_eq("glitch_errcnt",   32'(bus.ERR_CNT), 32'd1);
        check_eq("glitch_lock",     32'(bus.LOCK),    32'd1);

        // double break: 5 -> 9 -> 3 unlocks, 4,5,6 relocks
        feed_seq("to5b", 11, 11);
        drive("brk9", 1'b1, 9);
        drive("brk3", 1'b1, 3);
        check_eq("brk_unlock", 32'(bus.LOCK),    32'd0);
        check_eq("brk_errcnt", 32'(bus.ERR_CNT), 32'd3);
        feed_seq("relock", 4, 3);
        check_eq("relock_lock", 32'(bus.LOCK), 32'd1);

        // EN low holds everything regardless of DIN
        for (int i = 0; i < 5; i++) drive("hold", 1'b0, int'($urandom_range(0, 15)));
        drive("resume", 1'b1, 7);
        check_eq("resume_lock", 32'(bus.LOCK), 32'd1);
        check_eq("resume_err",  32'(bus.ERR),  32'd0);

        // random traffic: mostly correct successors, some breaks and stalls
        v = 7;
        for (int i = 0; i < 200; i++) begin
            bit en;
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 5) == 0) v = int'($urandom_range(0, 15));
            else if (en) v = m_next(v);
            drive("rand", en, v);
        end

        // saturate ERR_CNT with bad/good pairs while locked
        v = int'($urandom_range(0, 15));
        feed_seq("prelock", v, 4);
        v = (m_prev + 6) % (MAX + 1);
        for (int i = 0; i < 300; i++) begin
            drive("sat_bad", 1'b1, v);
            v = m_next(v);
            drive("sat_good", 1'b1, v);
            v = (v + 6) % (MAX + 1);
        end
        check_eq("sat_errcnt", 32'(bus.ERR_CNT), 32'd255);
        check_eq("sat_lock",   32'(bus.LOCK),    32'd1);

        // asynchronous reset between edges
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_lock",   32'(bus.LOCK),    32'd0);
        check_eq("arst_err",    32'(bus.ERR),     32'd0);
        check_eq("arst_errcnt", 32'(bus.ERR_CNT), 32'd0);
        check_eq("arst_exp",    32'(bus.EXP),     32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        feed_seq("post", 9, 5);

        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
